// File: rtl/rsp_rx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsp_rx_pkg : response framing constants and payload sizing helper. rev 1.0
// ---------------------------------------------------------------------------
package rsp_rx_pkg;

    localparam logic [7:0] CMD_TX_START = 8'hA5;
    localparam int         RSP_HDR_LEN  = 5;

    typedef enum logic [1:0] {
        RSP_WSZ_NONE = 2'b00,
        RSP_WSZ_8    = 2'b01,
        RSP_WSZ_16   = 2'b10,
        RSP_WSZ_32   = 2'b11
    } rsp_wsz_e;

    // Index of the final payload byte: ((wcnt+1) << (wsz-1)) - 1, at most 1023.
    function automatic logic [9:0] pl_last_index(input logic [7:0] wcnt,
                                                 input logic [1:0] wsz);
        logic [10:0] words;
        logic [10:0] len;
        words = {3'b000, wcnt} + 11'd1;
        case (wsz)
            RSP_WSZ_16: len = words << 1;
            RSP_WSZ_32: len = words << 2;
            default:    len = words;
        endcase
        return 10'(len - 11'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_rx_crc8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsp_rx_crc8 : combinational CRC-8 (poly 0x07, MSB first) one-byte update. rev 1.0
// ---------------------------------------------------------------------------
module rsp_rx_crc8 (
    input  logic [7:0] i_data,
    input  logic [7:0] i_crc,
    output logic [7:0] o_crc
);

    logic [7:0] c;

    always_comb begin
        c = i_crc ^ i_data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        o_crc = c;
    end

endmodule
`default_nettype wire

// File: rtl/rsp_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsp_rx : response-stream decoder (START hunt, header CRC8, payload pass-through). rev 1.0
// ---------------------------------------------------------------------------
module rsp_rx
    import rsp_rx_pkg::*;
#(
    parameter logic [7:0] START_BYTE = CMD_TX_START
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    output logic       o_hdr_valid,
    input  logic       i_hdr_ready,
    output logic [7:0] o_hdr_tag,
    output logic [7:0] o_hdr_wcnt,
    output logic [1:0] o_hdr_wsz,
    output logic [7:0] o_pl_data,
    output logic       o_pl_valid,
    input  logic       i_pl_ready,
    output logic       o_pl_last,
    output logic       o_crc_err,
    output logic       o_sync_err
);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_DSC  = 3'd1,
        ST_TAG  = 3'd2,
        ST_WCNT = 3'd3,
        ST_CRC  = 3'd4,
        ST_HDR  = 3'd5,
        ST_DATA = 3'd6
    } state_e;

    state_e     state;
    state_e     state_nxt;
    logic [7:0] crc_acc;
    logic [7:0] crc_seed;
    logic [7:0] crc_next;
    logic [7:0] tag;
    logic [7:0] wcnt;
    logic [1:0] wsz;
    logic [9:0] pl_cnt;
    logic       rx_ack;
    logic       hdr_ack;
    logic       is_start;
    logic       crc_ok;
    logic       crc_err;
    logic       sync_err;

    assign is_start = (i_rx_data == START_BYTE);
    assign crc_ok   = (i_rx_data == crc_acc);

    always_comb begin
        o_rx_ready = 1'b1;
        if (state == ST_HDR) begin
            o_rx_ready = 1'b0;
        end else if (state == ST_DATA) begin
            o_rx_ready = i_pl_ready;
        end
    end

    assign rx_ack      = i_rx_valid && o_rx_ready;
    assign o_hdr_valid = (state == ST_HDR);
    assign hdr_ack     = o_hdr_valid && i_hdr_ready;

    // The START byte seeds the accumulator from zero; later header bytes chain on.
    assign crc_seed = (state == ST_HUNT) ? 8'h00 : crc_acc;

    rsp_rx_crc8 u_crc8 (
        .i_data (i_rx_data),
        .i_crc  (crc_seed),
        .o_crc  (crc_next)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: if (rx_ack && is_start) state_nxt = ST_DSC;
            ST_DSC:  if (rx_ack) state_nxt = ST_TAG;
            ST_TAG:  if (rx_ack) state_nxt = ST_WCNT;
            ST_WCNT: if (rx_ack) state_nxt = ST_CRC;
            ST_CRC:  if (rx_ack) state_nxt = crc_ok ? ST_HDR : ST_HUNT;
            ST_HDR:  if (hdr_ack) state_nxt = (wsz == RSP_WSZ_NONE) ? ST_HUNT : ST_DATA;
            ST_DATA: if (rx_ack && (pl_cnt == 10'd0)) state_nxt = ST_HUNT;
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_HUNT;
            crc_acc  <= 8'h00;
            tag      <= 8'h00;
            wcnt     <= 8'h00;
            wsz      <= 2'b00;
            pl_cnt   <= 10'd0;
            crc_err  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_err <= (state == ST_HUNT) && rx_ack && !is_start;
            crc_err  <= (state == ST_CRC) && rx_ack && !crc_ok;

            if (rx_ack) begin
                case (state)
                    ST_HUNT: if (is_start) crc_acc <= crc_next;
                    ST_DSC: begin
                        wsz     <= i_rx_data[1:0];
                        crc_acc <= crc_next;
                    end
                    ST_TAG: begin
                        tag     <= i_rx_data;
                        crc_acc <= crc_next;
                    end
                    ST_WCNT: begin
                        wcnt    <= i_rx_data;
                        crc_acc <= crc_next;
                    end
                    ST_DATA: if (pl_cnt != 10'd0) pl_cnt <= pl_cnt - 10'd1;
                    default: ;
                endcase
            end

            if (hdr_ack) begin
                pl_cnt <= pl_last_index(wcnt, wsz);
            end
        end
    end

    assign o_hdr_tag  = tag;
    assign o_hdr_wcnt = wcnt;
    assign o_hdr_wsz  = wsz;
    assign o_pl_data  = i_rx_data;
    assign o_pl_valid = (state == ST_DATA) && i_rx_valid;
    assign o_pl_last  = o_pl_valid && (pl_cnt == 10'd0);
    assign o_crc_err  = crc_err;
    assign o_sync_err = sync_err;

endmodule
`default_nettype wire

// File: tb/tb_rsp_rx.sv
`default_nettype none
// tb_rsp_rx : randomized self-checking bench for the response-stream decoder.
module tb_rsp_rx;
    import rsp_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [7:0] hdr_tag;
    logic [7:0] hdr_wcnt;
    logic [1:0] hdr_wsz;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       pl_last;
    logic       crc_err;
    logic       sync_err;

    rsp_rx #(.START_BYTE(8'hA5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_hdr_valid (hdr_valid),
        .i_hdr_ready (hdr_ready),
        .o_hdr_tag   (hdr_tag),
        .o_hdr_wcnt  (hdr_wcnt),
        .o_hdr_wsz   (hdr_wsz),
        .o_pl_data   (pl_data),
        .o_pl_valid  (pl_valid),
        .i_pl_ready  (pl_ready),
        .o_pl_last   (pl_last),
        .o_crc_err   (crc_err),
        .o_sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc = 0;
    int hdr_pct = 100;
    int pl_pct = 100;
    int gap_pct = 0;
    bit abort;

    logic [7:0]  tx_q[$];
    logic [17:0] exp_hdr[$];
    logic [17:0] obs_hdr[$];
    logic [8:0]  exp_pl[$];
    logic [8:0]  obs_pl[$];
    int n_sync, n_crc, n_unstable, n_overlap, n_rdy_bad;
    logic        pend = 1'b0;
    logic [17:0] pend_hdr;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        hdr_ready = 1'b1;
        pl_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hdr_ready = ($urandom_range(99) < hdr_pct);
            pl_ready  = ($urandom_range(99) < pl_pct);
        end
    end

    // Observer: records what the DUT hands over; handshakes complete at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend && (!hdr_valid || {hdr_tag, hdr_wcnt, hdr_wsz} !== pend_hdr)) n_unstable++;
            if (hdr_valid && (crc_err || sync_err)) n_overlap++;
            if (pl_valid && (rx_ready !== pl_ready)) n_rdy_bad++;
            if (crc_err) n_crc++;
            if (sync_err) n_sync++;
            if (hdr_valid && hdr_ready) obs_hdr.push_back({hdr_tag, hdr_wcnt, hdr_wsz});
            if (pl_valid && pl_ready) obs_pl.push_back({pl_last, pl_data});
            pend     = hdr_valid && !hdr_ready;
            pend_hdr = {hdr_tag, hdr_wcnt, hdr_wsz};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // CRC-8 as polynomial long division by x^8+x^2+x+1.
    function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] d);
        logic [15:0] r;
        r = {crc ^ d, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic clear_sb();
        tx_q.delete(); exp_hdr.delete(); obs_hdr.delete(); exp_pl.delete(); obs_pl.delete();
        n_sync = 0; n_crc = 0; n_unstable = 0; n_overlap = 0; n_rdy_bad = 0;
        abort = 1'b0;
    endtask

    task automatic make_frame(input logic [7:0] tag, input logic [7:0] wcnt, input logic [1:0] wsz,
                              input logic [5:0] dsc_hi, input bit corrupt, input bit avoid_start);
        logic [7:0] hdr [RSP_HDR_LEN];
        logic [7:0] crc;
        logic [7:0] b;
        int n;
        hdr[0] = 8'hA5;
        hdr[1] = {dsc_hi, wsz};
        hdr[2] = tag;
        hdr[3] = wcnt;
        crc = 8'h00;
        for (int i = 0; i < RSP_HDR_LEN - 1; i++) crc = crc8_ref(crc, hdr[i]);
        hdr[4] = corrupt ? (crc ^ 8'h01) : crc;
        for (int i = 0; i < RSP_HDR_LEN; i++) tx_q.push_back(hdr[i]);
        if (!corrupt) exp_hdr.push_back({tag, wcnt, wsz});
        n = (wsz == 2'd0) ? 0 : (int'(wcnt) + 1) * ((wsz == 2'd1) ? 1 : (wsz == 2'd2) ? 2 : 4);
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (avoid_start && b == 8'hA5);
            tx_q.push_back(b);
            if (!corrupt) exp_pl.push_back({(i == n - 1), b});
        end
    endtask

    task automatic send();
        int  waitc;
        bit  acc;
        while (tx_q.size() > 0 && !abort) begin
            while ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            rx_data  = tx_q.pop_front();
            rx_valid = 1'b1;
            waitc    = 0;
            forever begin
                @(negedge clk);
                acc = rx_ready;
                @(posedge clk);
                #1;
                if (acc || abort) break;
                waitc++;
                if (waitc > 3000) begin
                    total++; bad++;
                    $display("FAIL send_timeout byte=%h not accepted in 3000 cycles", rx_data);
                    abort = 1'b1;
                    break;
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((obs_hdr.size() < exp_hdr.size() || obs_pl.size() < exp_pl.size()) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) begin
            total++; bad++;
            $display("FAIL %s drain_timeout hdr got=%0d exp=%0d pl got=%0d exp=%0d",
                     name, obs_hdr.size(), exp_hdr.size(), obs_pl.size(), exp_pl.size());
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        total++;
        if ({hdr_valid, pl_valid, pl_last, crc_err, sync_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {hdr_valid, pl_valid, pl_last, crc_err, sync_err});
        end
        total++;
        if ({hdr_tag, hdr_wcnt, hdr_wsz} !== 18'h0) begin
            bad++;
            $display("FAIL reset_hdr got=%h exp=0", {hdr_tag, hdr_wcnt, hdr_wsz});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_rx_ready got=%b exp=1", rx_ready);
        end
    endtask

    task automatic test_no_data();
        clear_sb();
        make_frame(8'h3C, 8'h07, 2'b00, 6'h00, 1'b0, 1'b0);
        make_frame(8'hA5, 8'hA5, 2'b00, 6'h29, 1'b0, 1'b0);
        send();
        wait_drain("nodata");
        total++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            bad++; $display("FAIL nodata_hdr_count got=%0d exp=%0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL nodata_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        total++;
        if (obs_pl.size() != 0 || pl_valid !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL nodata_idle pl_count=%0d pl_valid=%b rx_ready=%b exp 0/0/1", obs_pl.size(), pl_valid, rx_ready);
        end
        total++;
        if (n_sync != 0 || n_crc != 0) begin
            bad++; $display("FAIL nodata_errs sync=%0d crc=%0d exp 0/0", n_sync, n_crc);
        end
    endtask

    task automatic test_payload();
        clear_sb();
        make_frame(8'h11, 8'd1, 2'b10, 6'($urandom), 1'b0, 1'b0);
        make_frame(8'h22, 8'd255, 2'b11, 6'($urandom), 1'b0, 1'b0);
        send();
        wait_drain("payload");
        total++;
        if (obs_hdr.size() != exp_hdr.size() || obs_pl.size() != exp_pl.size()) begin
            bad++;
            $display("FAIL payload_counts hdr got=%0d exp=%0d pl got=%0d exp=%0d",
                     obs_hdr.size(), exp_hdr.size(), obs_pl.size(), exp_pl.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL payload_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            total++;
            if (obs_pl[i] !== exp_pl[i]) begin
                bad++; $display("FAIL payload_byte[%0d] got=%h exp=%h (bit8=last)", i, obs_pl[i], exp_pl[i]);
            end
        end
    endtask

    task automatic test_sync();
        clear_sb();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        make_frame(8'($urandom), 8'd2, 2'b01, 6'($urandom), 1'b0, 1'b0);
        send();
        wait_drain("sync");
        total++;
        if (n_sync != 3 || n_crc != 0) begin
            bad++; $display("FAIL sync_pulses sync=%0d crc=%0d exp 3/0", n_sync, n_crc);
        end
        total++;
        if (obs_hdr.size() != 1 || (obs_hdr.size() == 1 && obs_hdr[0] !== exp_hdr[0])) begin
            bad++; $display("FAIL sync_hdr count=%0d exp=1 exp_hdr=%h", obs_hdr.size(), exp_hdr[0]);
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            total++;
            if (obs_pl[i] !== exp_pl[i]) begin
                bad++; $display("FAIL sync_byte[%0d] got=%h exp=%h", i, obs_pl[i], exp_pl[i]);
            end
        end
    endtask

    task automatic test_crc_err();
        clear_sb();
        make_frame(8'h5C, 8'd3, 2'b01, 6'($urandom), 1'b1, 1'b1);
        make_frame(8'h6D, 8'd2, 2'b01, 6'($urandom), 1'b0, 1'b0);
        send();
        wait_drain("crc");
        total++;
        if (n_crc != 1 || n_sync != 4) begin
            bad++; $display("FAIL crc_pulses crc=%0d sync=%0d exp 1/4", n_crc, n_sync);
        end
        total++;
        if (n_overlap != 0) begin
            bad++; $display("FAIL crc_overlap got=%0d exp=0", n_overlap);
        end
        total++;
        if (obs_hdr.size() != 1 || obs_pl.size() != exp_pl.size()) begin
            bad++; $display("FAIL crc_counts hdr=%0d exp=1 pl=%0d exp=%0d", obs_hdr.size(), obs_pl.size(), exp_pl.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL crc_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            total++;
            if (obs_pl[i] !== exp_pl[i]) begin
                bad++; $display("FAIL crc_byte[%0d] got=%h exp=%h", i, obs_pl[i], exp_pl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_sb();
        for (int f = 0; f < 4; f++) make_frame(8'($urandom), 8'($urandom), 2'b00, 6'($urandom), 1'b0, 1'b0);
        c0 = cyc;
        send();
        total++;
        if (cyc - c0 != 23) begin
            bad++; $display("FAIL b2b_cycles got=%0d exp=23", cyc - c0);
        end
        wait_drain("b2b");
        total++;
        if (obs_hdr.size() != exp_hdr.size()) begin
            bad++; $display("FAIL b2b_hdr_count got=%0d exp=%0d", obs_hdr.size(), exp_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL b2b_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        hdr_pct = 40; pl_pct = 50; gap_pct = 30;
        for (int f = 0; f < 8; f++) begin
            make_frame(8'($urandom), 8'($urandom_range(15)), 2'($urandom), 6'($urandom), 1'b0, 1'b0);
        end
        send();
        wait_drain("bp");
        hdr_pct = 100; pl_pct = 100; gap_pct = 0;
        total++;
        if (obs_hdr.size() != exp_hdr.size() || obs_pl.size() != exp_pl.size()) begin
            bad++;
            $display("FAIL bp_counts hdr got=%0d exp=%0d pl got=%0d exp=%0d",
                     obs_hdr.size(), exp_hdr.size(), obs_pl.size(), exp_pl.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL bp_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            total++;
            if (obs_pl[i] !== exp_pl[i]) begin
                bad++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, obs_pl[i], exp_pl[i]);
            end
        end
        total++;
        if (n_unstable != 0 || n_rdy_bad != 0 || n_overlap != 0) begin
            bad++;
            $display("FAIL bp_protocol unstable=%0d rdy_mismatch=%0d overlap=%0d exp 0/0/0", n_unstable, n_rdy_bad, n_overlap);
        end
        total++;
        if (n_sync != 0 || n_crc != 0) begin
            bad++; $display("FAIL bp_errs sync=%0d crc=%0d exp 0/0", n_sync, n_crc);
        end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        make_frame(8'h77, 8'd20, 2'b11, 6'($urandom), 1'b0, 1'b0);
        fork
            send();
            begin
                repeat (12) @(posedge clk);
                #3;
                total++;
                if (pl_valid !== 1'b1) begin
                    bad++; $display("FAIL rstmid_in_payload pl_valid=%b exp=1", pl_valid);
                end
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                total++;
                if ({hdr_valid, pl_valid, pl_last, crc_err, sync_err} !== 5'b0) begin
                    bad++;
                    $display("FAIL rstmid_flags got=%b exp=00000", {hdr_valid, pl_valid, pl_last, crc_err, sync_err});
                end
            end
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_sb();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (n_sync != 0 || n_crc != 0) begin
            bad++; $display("FAIL rstmid_silent sync=%0d crc=%0d exp 0/0", n_sync, n_crc);
        end
        make_frame(8'h88, 8'd5, 2'b01, 6'($urandom), 1'b0, 1'b0);
        send();
        wait_drain("rstmid");
        total++;
        if (obs_hdr.size() != 1 || obs_pl.size() != exp_pl.size() || n_sync != 0 || n_crc != 0) begin
            bad++;
            $display("FAIL rstmid_next hdr=%0d exp=1 pl=%0d exp=%0d sync=%0d crc=%0d",
                     obs_hdr.size(), obs_pl.size(), exp_pl.size(), n_sync, n_crc);
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            total++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                bad++; $display("FAIL rstmid_hdr[%0d] got=%h exp=%h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        foreach (exp_pl[i]) if (i < obs_pl.size()) begin
            total++;
            if (obs_pl[i] !== exp_pl[i]) begin
                bad++; $display("FAIL rstmid_byte[%0d] got=%h exp=%h", i, obs_pl[i], exp_pl[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        abort = 1'b0;
        test_reset();
        test_no_data();
        test_payload();
        test_sync();
        test_crc_err();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
